// File: rtl/cdc_hs_tx_arbiter.sv
// Two-requester round-robin arbiter driving a 4-phase req/ack handshake into another clock domain.
// Latency: accept to o_req high is 1 cycle; o_done pulses in the first IDLE cycle after ack falls.
// Backpressure: o_ready stays low while a handshake is in flight, while ack is high, and in the o_done cycle.
module cdc_hs_tx_arbiter #(
   parameter int DATA_W      = 16,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [1:0]        i_valid,
   input  logic [DATA_W-1:0] i_data0,
   input  logic [DATA_W-1:0] i_data1,
   output logic [1:0]        o_ready,
   output logic              o_req,
   output logic [DATA_W-1:0] o_data,
   input  logic              i_ack_sync,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_done_id,
   output logic              o_timeout
);

   // A zero timeout still needs a legal 1-bit counter; the compare is disabled instead.
   localparam int              CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
   localparam bit              TMO_EN  = (TIMEOUT_CYC != 0);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic [DATA_W-1:0] data_q;
   logic              idx_q;
   logic              last_q;
   logic              done_q, done_d;
   logic              abort_q, abort_d;

   logic [1:0]        ready_s;
   logic              sel_s;
   logic              grant_ok_s;
   logic              accept_s;
   logic              expired_s;
   logic              timeout_s;

   // Round-robin pick and combinational accept; reset forces o_ready low.
   always_comb begin
      ready_s    = 2'b00;
      sel_s      = 1'b0;
      grant_ok_s = i_rst_n && (state_q == ST_IDLE) && !i_ack_sync && !done_q;
      if (i_valid == 2'b11) begin
         sel_s = ~last_q;
      end else begin
         sel_s = i_valid[1];
      end
      if (grant_ok_s && i_valid[sel_s]) begin
         ready_s[sel_s] = 1'b1;
      end
      accept_s = |(i_valid & ready_s);
   end

   assign expired_s = TMO_EN && (cnt_q == CNT_MAX);

   // Next-state and pulse decode; an ack edge beats a coincident counter expiry.
   always_comb begin
      state_d   = state_q;
      done_d    = 1'b0;
      abort_d   = abort_q;
      timeout_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_REQ;
               abort_d = 1'b0;
            end
         end
         ST_REQ: begin
            if (i_ack_sync) begin
               state_d = ST_RELEASE;
            end else if (expired_s) begin
               // Abandoned transfer still passes through RELEASE so req is seen low, but never reports done.
               state_d   = ST_RELEASE;
               timeout_s = 1'b1;
               abort_d   = 1'b1;
            end
         end
         ST_RELEASE: begin
            if (!i_ack_sync) begin
               state_d = ST_IDLE;
               done_d  = !abort_q;
            end else if (expired_s) begin
               state_d   = ST_IDLE;
               timeout_s = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      req_d = (state_d == ST_REQ);
      if ((state_d != state_q) || (state_q == ST_IDLE)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Control state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         done_q  <= done_d;
         abort_q <= abort_d;
      end
   end

   // Payload, winner index and round-robin pointer update only on accept.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         data_q <= '0;
         idx_q  <= 1'b0;
         last_q <= 1'b1;
      end else if (accept_s) begin
         data_q <= sel_s ? i_data1 : i_data0;
         idx_q  <= sel_s;
         last_q <= sel_s;
      end
   end

   assign o_ready   = ready_s;
   assign o_req     = req_q;
   assign o_data    = data_q;
   assign o_busy    = (state_q != ST_IDLE);
   assign o_done    = done_q;
   assign o_done_id = idx_q;
   assign o_timeout = timeout_s;

endmodule

// File: tb/tb_cdc_hs_tx_arbiter.sv
// Directed bench for cdc_hs_tx_arbiter with a per-cycle handshake model and literal spot checks.
// Latency: inputs change 1 time unit after the rising edge; the model compares on the falling edge.
// Backpressure: the bench drives the ack side reactively from o_req.
module tb_cdc_hs_tx_arbiter;

   localparam int DW = 16;
   localparam int T  = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    valid;
   logic [DW-1:0] d0, d1;
   logic          ack;
   logic [1:0]    o_ready;
   logic          o_req;
   logic [DW-1:0] o_data;
   logic          o_busy, o_done, o_done_id, o_timeout;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cdc_hs_tx_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(T)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_valid    (valid),
      .i_data0    (d0),
      .i_data1    (d1),
      .o_ready    (o_ready),
      .o_req      (o_req),
      .o_data     (o_data),
      .i_ack_sync (ack),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_done_id  (o_done_id),
      .o_timeout  (o_timeout)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Handshake stage: 0 = no transfer, 1 = waiting for ack to rise, 2 = waiting for ack to fall.
   int            m_stage;
   int            m_age;      // cycles spent so far in the current stage
   bit            m_last;     // requester that won most recently
   bit            m_id;
   bit            m_done;     // o_done expected in this cycle
   bit            m_abort;    // current transfer was abandoned
   logic [DW-1:0] m_data;

   task automatic model_reset();
      m_stage = 0;
      m_age   = 0;
      m_last  = 1'b1;
      m_id    = 1'b0;
      m_done  = 1'b0;
      m_abort = 1'b0;
      m_data  = '0;
   endtask

   initial model_reset();

   always @(negedge clk) begin
      logic [1:0] e_rdy;
      bit         e_tmo;
      if (!rst_n) model_reset();
      e_rdy = 2'b00;
      if (rst_n && m_stage == 0 && !ack && !m_done) begin
         if (valid == 2'b11)      e_rdy = m_last ? 2'b01 : 2'b10;
         else if (valid == 2'b01) e_rdy = 2'b01;
         else if (valid == 2'b10) e_rdy = 2'b10;
      end
      e_tmo = rst_n && (m_age == T) &&
              ((m_stage == 1 && !ack) || (m_stage == 2 && ack));
      chk("m_ready",   o_ready,   e_rdy);
      chk("m_req",     o_req,     (m_stage == 1));
      chk("m_busy",    o_busy,    (m_stage != 0));
      chk("m_data",    o_data,    m_data);
      chk("m_done",    o_done,    m_done);
      chk("m_timeout", o_timeout, e_tmo);
      if (m_done || e_tmo) chk("m_done_id", o_done_id, m_id);
      if (rst_n) begin
         m_done = 1'b0;
         case (m_stage)
            0: if (e_rdy != 2'b00) begin
                  m_stage = 1; m_age = 0; m_abort = 1'b0;
                  m_id = e_rdy[1]; m_last = e_rdy[1];
                  m_data = e_rdy[1] ? d1 : d0;
               end
            1: if (ack) begin
                  m_stage = 2; m_age = 0;
               end else if (m_age == T) begin
                  m_stage = 2; m_age = 0; m_abort = 1'b1;
               end else m_age++;
            2: if (!ack) begin
                  m_stage = 0; m_age = 0; m_done = !m_abort;
               end else if (m_age == T) begin
                  m_stage = 0; m_age = 0;
               end else m_age++;
            default: m_stage = 0;
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input logic lvl, input string nm);
      int n;
      n = 0;
      while (o_req !== lvl && n < 40) begin
         tick();
         n++;
      end
      if (o_req !== lvl) chk(nm, o_req, lvl);
   endtask

   // Answer one request: ack rises rise_d cycles after o_req, falls fall_d cycles after o_req drops.
   task automatic handshake(input int rise_d, input int fall_d, output bit id);
      wait_req(1'b1, "hs_wait_req_hi");
      repeat (rise_d) tick();
      ack = 1'b1;
      wait_req(1'b0, "hs_wait_req_lo");
      repeat (fall_d) tick();
      ack = 1'b0;
      tick();
      chk("hs_done", o_done, 1'b1);
      id = o_done_id;
   endtask

   initial begin
      #100000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      bit id;
      bit grants [4];
      int k;
      rst_n = 1'b0; valid = 2'b11; d0 = '0; d1 = '0; ack = 1'b0;
      #2;
      chk("rst_ready", o_ready, 2'b00);
      chk("rst_req",   o_req,   1'b0);
      chk("rst_data",  o_data,  16'h0000);
      chk("rst_busy",  o_busy,  1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1; valid = 2'b00;
      tick();

      // Single transfer from requester 0.
      d0 = 16'hA5A5; valid = 2'b01;
      #1;
      chk("t1_ready", o_ready, 2'b01);
      tick();
      valid = 2'b00;
      #1;
      chk("t1_req",  o_req,  1'b1);
      chk("t1_data", o_data, 16'hA5A5);
      handshake(3, 3, id);
      chk("t1_id", id, 1'b0);

      // Contention straight after reset alternates 0,1,0,1.
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      d0 = 16'h1111; d1 = 16'h2222; valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         handshake(1, 1, id);
         grants[i] = id;
      end
      valid = 2'b00;
      chk("t2_g0", grants[0], 1'b0);
      chk("t2_g1", grants[1], 1'b1);
      chk("t2_g2", grants[2], 1'b0);
      chk("t2_g3", grants[3], 1'b1);
      tick();

      // REQ timeout with ack held low.
      d0 = 16'h0F0F; valid = 2'b01;
      tick();
      valid = 2'b00;
      k = 0;
      while (!o_timeout && k < 20) begin
         tick();
         k++;
      end
      chk("t3_tmo_delay", k, 8);
      tick();
      chk("t3_req_low", o_req,     1'b0);
      chk("t3_tmo_one", o_timeout, 1'b0);
      chk("t3_busy",    o_busy,    1'b1);
      tick();
      chk("t3_idle", o_busy, 1'b0);
      chk("t3_nodone", o_done, 1'b0);

      // Ack stuck high: RELEASE times out, then ack gates grants in IDLE.
      d1 = 16'hBEEF; valid = 2'b10;
      tick();
      valid = 2'b00;
      tick();
      ack = 1'b1;
      wait_req(1'b0, "t4_wait_req_lo");
      k = 0;
      while (!o_timeout && k < 20) begin
         tick();
         k++;
      end
      chk("t4_tmo_delay", k, 8);
      tick();
      chk("t4_idle", o_busy, 1'b0);
      valid = 2'b10;
      #1;
      chk("t4_blocked0", o_ready, 2'b00);
      tick();
      chk("t4_blocked1", o_ready, 2'b00);
      ack = 1'b0;
      #1;
      chk("t4_ready", o_ready, 2'b10);
      tick();
      valid = 2'b00;
      handshake(1, 1, id);
      chk("t4_id", id, 1'b1);
      tick();

      // Reset in the middle of REQ.
      d0 = 16'h5A5A; valid = 2'b01;
      tick();
      valid = 2'b00;
      #1;
      chk("t5_req_before", o_req, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t5_req_async",  o_req,     1'b0);
      chk("t5_busy_async", o_busy,    1'b0);
      chk("t5_no_tmo",     o_timeout, 1'b0);
      tick(); tick();
      rst_n = 1'b1;
      #1;
      chk("t5_busy_after", o_busy, 1'b0);
      valid = 2'b11;
      #1;
      chk("t5_ready", o_ready, 2'b01);
      tick();
      valid = 2'b00;
      handshake(2, 2, id);
      chk("t5_id", id, 1'b0);
      tick();

      // Ack rises exactly on REQ expiry; later ack falls exactly on RELEASE expiry.
      d0 = 16'hC3C3; valid = 2'b01;
      tick();
      valid = 2'b00;
      repeat (8) tick();
      ack = 1'b1;
      #1;
      chk("t6_no_tmo_req", o_timeout, 1'b0);
      tick();
      chk("t6_req_low", o_req,  1'b0);
      chk("t6_release", o_busy, 1'b1);
      repeat (8) tick();
      ack = 1'b0;
      #1;
      chk("t6_no_tmo_rel", o_timeout, 1'b0);
      tick();
      chk("t6_done", o_done, 1'b1);
      chk("t6_idle", o_busy, 1'b0);

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/cdc_hs_tx_arbiter.md
CDC_HS_TX_ARBITER -- requirements
Module: cdc_hs_tx_arbiter

Interface
REQ-001 Parameter: DATA_W, default 16, width of each requester's data bus and of o_data.
REQ-002 Parameter: TIMEOUT_CYC, default 64, cycles to wait for an ack edge; 0 disables the timeout.
REQ-003 i_clk  input  1  source-domain clock.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_valid  input  2  per-requester transfer request; bit n belongs to requester n.
REQ-006 i_data0 / i_data1  input  DATA_W each  payload of requester 0 / 1.
REQ-007 o_ready  output  2  per-requester accept; a transfer occurs when i_valid[n] & o_ready[n].
REQ-008 o_req  output  1  4-phase request to the destination domain, registered.
REQ-009 o_data  output  DATA_W  latched payload, registered, stable while o_req or o_busy is high.
REQ-010 i_ack_sync  input  1  destination ack, already passed through a 2-stage bit synchronizer into i_clk.
REQ-011 o_busy  output  1  high in any state other than IDLE.
REQ-012 o_done  output  1  one-cycle pulse when a handshake completes normally.
REQ-013 o_done_id  output  1  requester index of the completing or timed-out transfer, valid with o_done/o_timeout.
REQ-014 o_timeout  output  1  one-cycle pulse when a handshake is abandoned.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, REQ and RELEASE.
REQ-016 Grant in IDLE: eligible when state==IDLE, i_ack_sync==0 and the requester's i_valid is high.
REQ-017 o_ready SHALL be combinational from i_valid and state, with at most one bit high per cycle.
REQ-018 Arbitration SHALL be round-robin.
  - Both valid: grant the requester not granted last.
  - One valid: grant it.
REQ-019 On accept:
  - latch the selected data into o_data;
  - record the index;
  - update the last-grant pointer;
  - go to REQ.
  - o_req SHALL be 1 in the following cycle, giving 1-cycle accept-to-req latency.
REQ-020 REQ: hold o_req=1.
  - On i_ack_sync==1, go to RELEASE; o_req=0 from the next cycle.
REQ-021 RELEASE: hold o_req=0.
  - On i_ack_sync==0, go to IDLE and pulse o_done for one cycle in that IDLE-entry cycle.
REQ-022 No new grant SHALL occur in the cycle o_done pulses.
  - The earliest next accept is the following cycle, provided ack is still 0.
REQ-023 Timeout counter:
  - width $clog2(TIMEOUT_CYC+1);
  - cleared on every state entry;
  - increments each cycle in REQ or RELEASE.
REQ-024 Timeout in REQ: counter reaches TIMEOUT_CYC with no ack.
  - Pulse o_timeout; o_req=0 next cycle; go to RELEASE.
  - o_done SHALL NOT pulse for this transfer.
REQ-025 Timeout in RELEASE: counter reaches TIMEOUT_CYC with ack still 1.
  - Pulse o_timeout; go to IDLE.
  - The REQ-016 ack gate then blocks grants until ack falls.
REQ-026 Ack falls on the same cycle the counter expires in RELEASE: normal completion (o_done) SHALL win.
REQ-027 Ack rises on the same cycle the counter expires in REQ: the ack SHALL win (go to RELEASE, no o_timeout).
REQ-028 i_valid dropping after accept SHALL NOT affect the in-flight transfer.
REQ-029 o_data SHALL change only on accept.
REQ-030 i_ack_sync high while in IDLE SHALL be ignored, apart from blocking grants.

Reset
REQ-031 While i_rst_n==0, outputs SHALL be:
  - state=IDLE, o_req=0, o_data=0, o_busy=0;
  - o_done=0, o_timeout=0, o_done_id=0;
  - o_ready=0, forced regardless of i_valid;
  - counter=0.
REQ-032 The last-grant pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-033 Reset asserted mid-handshake SHALL drop o_req asynchronously with no o_done/o_timeout pulse.

Verification
REQ-034 Single transfer:
  - Stimulus: i_valid=01, i_data0=16'hA5A5; ack rises 3 cycles after o_req and falls 3 cycles after o_req drops.
  - Response: o_ready=01 for 1 cycle; o_req high the next cycle; o_data=A5A5; o_done=1 with o_done_id=0.
REQ-035 Contention after reset:
  - Stimulus: i_valid=11 held.
  - Response: grants alternate 0,1,0,1 across four complete handshakes.
REQ-036 Timeout in REQ:
  - Stimulus: TIMEOUT_CYC=8, ack held 0.
  - Response: o_timeout pulses 8 cycles after REQ entry; o_req=0; IDLE reached one cycle later; no o_done.
REQ-037 Stuck-high ack:
  - Stimulus: ack held 1 after completion attempt.
  - Response: RELEASE times out; IDLE entered; o_ready stays 00 with i_valid=10 until ack=0, then o_ready=10.
REQ-038 Reset mid-REQ:
  - Stimulus: assert i_rst_n=0 while o_req=1.
  - Response: o_req=0 immediately; after release, o_busy=0; next contention grants requester 0.
REQ-039 Simultaneous edge:
  - Stimulus: ack rises on the exact expiry cycle in REQ.
  - Response: RELEASE entered; o_timeout stays 0.
